// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, clear-FSM state type and width helper for the banked register file
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NBANK_DEF = 2;
   localparam int NRD_DEF   = 2;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/regfile_mbank_if.sv
// rtl/regfile_mbank_if.sv - read/write/clear bus between the PE pipeline and the banked register file
interface regfile_mbank_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF,
   parameter int NBANK = NBANK_DEF
);
   localparam int AW = idx_width(NREGS);
   localparam int BW = idx_width(NBANK);

   logic [BW-1:0]       bank_sel;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_valid;
   logic                wr_en;
   logic [BW-1:0]       wr_bank;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_drop;
   logic                clr_req;
   logic [BW-1:0]       clr_bank;
   logic                clr_busy;
   logic                clr_done;

   modport master (
      output bank_sel, rd_en, rd_addr, wr_en, wr_bank, wr_addr, wr_data, clr_req, clr_bank,
      input  rd_data, rd_valid, wr_drop, clr_busy, clr_done
   );

   modport slave (
      input  bank_sel, rd_en, rd_addr, wr_en, wr_bank, wr_addr, wr_data, clr_req, clr_bank,
      output rd_data, rd_valid, wr_drop, clr_busy, clr_done
   );
endinterface

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - one register context; clear write takes the single write port over the normal write
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int  XLEN  = XLEN_DEF,
   parameter int  NREGS = NREGS_DEF,
   localparam int AW    = idx_width(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [XLEN-1:0]       wdata_i,
   input  logic                  clr_i,
   input  logic [AW-1:0]         clr_addr_i,
   output logic [NREGS*XLEN-1:0] regs_o
);
   logic [NREGS*XLEN-1:0] regs_q;
   logic [AW-1:0]         addr;
   logic [XLEN-1:0]       data;

   assign addr = clr_i ? clr_addr_i : waddr_i;
   assign data = clr_i ? '0 : wdata_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else if (clr_i || we_i) begin
         regs_q[int'(addr)*XLEN +: XLEN] <= data;
      end
   end

   assign regs_o = regs_q;
endmodule

// File: rtl/regfile_mbank.sv
// rtl/regfile_mbank.sv - NBANK register contexts with NRD registered read ports, write bypass and a bank-clear engine
module regfile_mbank
   import regfile_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREGS   = NREGS_DEF,
   parameter int NRD     = NRD_DEF,
   parameter int NBANK   = NBANK_DEF,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   regfile_mbank_if.slave bus
);
   localparam int AW = idx_width(NREGS);
   localparam int BW = idx_width(NBANK);

   logic [NREGS*XLEN-1:0] bank_regs [NBANK];

   clr_state_t    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [BW-1:0] clr_bank_q, clr_bank_d;
   logic          done_q, done_d;
   logic          clr_we;
   logic          busy;
   logic          wr_r0, wr_hit_clr, wr_ok, drop_q;

   assign busy       = (state_q == CLEAR);
   assign wr_r0      = ZERO_R0 && (bus.wr_addr == '0);
   // Writes into the bank being cleared are lost; r0 writes are silently ignored, not counted as drops.
   assign wr_hit_clr = bus.wr_en && busy && (bus.wr_bank == clr_bank_q) && !wr_r0;
   assign wr_ok      = bus.wr_en && !wr_hit_clr && !wr_r0;

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      regfile_bank #(.XLEN(XLEN), .NREGS(NREGS)) u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .we_i       (wr_ok && (bus.wr_bank == BW'(b))),
         .waddr_i    (bus.wr_addr),
         .wdata_i    (bus.wr_data),
         .clr_i      (clr_we && (clr_bank_q == BW'(b))),
         .clr_addr_i (idx_q),
         .regs_o     (bank_regs[b])
      );
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_bank_d = clr_bank_q;
      done_d     = 1'b0;
      clr_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.clr_req) begin
               state_d    = CLEAR;
               clr_bank_d = bus.clr_bank;
               idx_d      = '0;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (idx_q == AW'(NREGS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               idx_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         clr_bank_q <= '0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         clr_bank_q <= clr_bank_d;
         done_q     <= done_d;
         drop_q     <= wr_hit_clr;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_port
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_d, data_q;
      logic            valid_q;

      assign addr = bus.rd_addr[p*AW +: AW];

      // The bank under clear reads as zero even for entries the engine has not reached yet.
      always_comb begin
         data_d = bank_regs[bus.bank_sel][int'(addr)*XLEN +: XLEN];
         if (busy && (bus.bank_sel == clr_bank_q)) data_d = '0;
         if (wr_ok && (bus.wr_bank == bus.bank_sel) && (bus.wr_addr == addr)) data_d = bus.wr_data;
         if (ZERO_R0 && (addr == '0)) data_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= bus.rd_en[p];
            if (bus.rd_en[p]) data_q <= data_d;
         end
      end

      assign bus.rd_data[p*XLEN +: XLEN] = data_q;
      assign bus.rd_valid[p]             = valid_q;
   end

   assign bus.wr_drop  = drop_q;
   assign bus.clr_busy = busy;
   assign bus.clr_done = done_q;
endmodule

// File: tb/tb_regfile_mbank.sv
// tb/tb_regfile_mbank.sv - scoreboard bench for regfile_mbank with directed read/write/clear vectors
module tb_regfile_mbank;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   regfile_mbank_if #(.XLEN(32), .NREGS(32), .NRD(2), .NBANK(2)) bus ();

   regfile_mbank #(.XLEN(32), .NREGS(32), .NRD(2), .NBANK(2), .ZERO_R0(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] data;
      int          id;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   clr_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   op_id    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic op(input logic [1:0] ren, input logic bsel,
                     input logic [4:0] a0, input logic [31:0] e0,
                     input logic [4:0] a1, input logic [31:0] e1,
                     input logic we, input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                     input logic creq, input logic cb);
      bus.bank_sel = bsel;
      bus.rd_en    = ren;
      bus.rd_addr  = {a1, a0};
      bus.wr_en    = we;
      bus.wr_bank  = wb;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.clr_req  = creq;
      bus.clr_bank = cb;
      if (ren[0]) q0.push_back('{data: e0, id: op_id});
      if (ren[1]) q1.push_back('{data: e1, id: op_id});
      op_id++;
      @(negedge clk);
      bus.rd_en   = '0;
      bus.wr_en   = 1'b0;
      bus.clr_req = 1'b0;
   endtask

   task automatic rd(input logic bsel, input logic [4:0] a0, input logic [31:0] e0,
                     input logic [4:0] a1, input logic [31:0] e1);
      op(2'b11, bsel, a0, e0, a1, e1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic b, input logic [4:0] a, input logic [31:0] d);
      op(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, b, a, d, 1'b0, 1'b0);
   endtask

   task automatic clr(input logic b);
      op(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, b);
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.clr_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("clr_done_seen", {31'b0, bus.clr_done}, 32'd1);
   endtask

   initial begin : monitor
      int   run = 0;
      int   last_run = 0;
      logic prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.rd_valid[0]) begin
            if (q0.size() == 0) flag("rd0_unexpected_valid");
            else begin
               e = q0.pop_front();
               chk($sformatf("rd0_data_op%0d", e.id), bus.rd_data[31:0], e.data);
            end
         end
         if (bus.rd_valid[1]) begin
            if (q1.size() == 0) flag("rd1_unexpected_valid");
            else begin
               e = q1.pop_front();
               chk($sformatf("rd1_data_op%0d", e.id), bus.rd_data[63:32], e.data);
            end
         end
         if (bus.clr_busy) run++;
         else if (run > 0) begin
            last_run = run;
            run = 0;
         end
         if (bus.clr_done) begin
            chk("clr_done_after_busy", {31'b0, prev_busy}, 32'd1);
            if (clr_q.size() == 0) flag("clr_done_unexpected");
            else chk("clr_busy_len", last_run, clr_q.pop_front());
         end
         prev_busy = bus.clr_busy;
      end
   end

   initial begin : stimulus
      rst_n        = 1'b0;
      bus.bank_sel = '0;
      bus.rd_en    = '0;
      bus.rd_addr  = '0;
      bus.wr_en    = 1'b0;
      bus.wr_bank  = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.clr_req  = 1'b0;
      bus.clr_bank = '0;
      repeat (2) @(negedge clk);
      chk("reset_rd_valid", bus.rd_valid, 32'd0);
      chk("reset_rd_data0", bus.rd_data[31:0], 32'd0);
      chk("reset_wr_drop", bus.wr_drop, 32'd0);
      chk("reset_clr_busy", bus.clr_busy, 32'd0);
      chk("reset_clr_done", bus.clr_done, 32'd0);
      rst_n = 1'b1;

      rd(1'b0, 5'd5, 32'h0, 5'd5, 32'h0);
      chk("rd_valid_both", bus.rd_valid, 32'd3);
      wr(1'b1, 5'd3, 32'hAAAA0003);
      chk("wr_drop_normal", bus.wr_drop, 32'd0);
      rd(1'b1, 5'd3, 32'hAAAA0003, 5'd3, 32'hAAAA0003);
      rd(1'b0, 5'd3, 32'h0, 5'd3, 32'h0);

      op(2'b11, 1'b0, 5'd7, 32'h12345678, 5'd5, 32'h0, 1'b1, 1'b0, 5'd7, 32'h12345678, 1'b0, 1'b0);
      @(negedge clk);
      chk("rd_valid_idle", bus.rd_valid, 32'd0);
      chk("rd_data0_hold", bus.rd_data[31:0], 32'h12345678);

      op(2'b01, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("wr_drop_r0", bus.wr_drop, 32'd0);
      rd(1'b0, 5'd0, 32'h0, 5'd7, 32'h12345678);

      for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'hAAAA0000 | i);
      rd(1'b1, 5'd31, 32'hAAAA001F, 5'd0, 32'h0);

      clr_q.push_back(32);
      op(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd2, 32'h00000055, 1'b1, 1'b1);
      rd(1'b1, 5'd31, 32'h0, 5'd1, 32'h0);
      wr(1'b1, 5'd9, 32'hDEAD0009);
      chk("wr_drop_clr_bank", bus.wr_drop, 32'd1);
      op(2'b11, 1'b0, 5'd9, 32'hBEEF0009, 5'd7, 32'h12345678, 1'b1, 1'b0, 5'd9, 32'hBEEF0009, 1'b0, 1'b0);
      chk("wr_drop_other_bank", bus.wr_drop, 32'd0);
      clr(1'b0);
      wait_done();

      clr_q.push_back(32);
      clr(1'b1);
      chk("clr_busy_back_to_back", bus.clr_busy, 32'd1);
      wait_done();

      rd(1'b1, 5'd9, 32'h0, 5'd2, 32'h0);
      rd(1'b1, 5'd3, 32'h0, 5'd31, 32'h0);
      rd(1'b0, 5'd7, 32'h12345678, 5'd9, 32'hBEEF0009);

      wr(1'b0, 5'd4, 32'h00000044);
      clr_q.push_back(32);
      clr(1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      void'(clr_q.pop_back());
      @(negedge clk);
      chk("midclr_reset_busy", bus.clr_busy, 32'd0);
      chk("midclr_reset_done", bus.clr_done, 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      rd(1'b0, 5'd4, 32'h0, 5'd7, 32'h0);
      rd(1'b0, 5'd9, 32'h0, 5'd1, 32'h0);
      repeat (2) @(negedge clk);

      chk("rd0_queue_drained", q0.size(), 32'd0);
      chk("rd1_queue_drained", q1.size(), 32'd0);
      chk("clr_queue_drained", clr_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mbank.md
# regfile_mbank

Parametrised multi-bank, multi-read-port register file for the RISC-V PE. It is the successor of the 32:1 dual read mux.

- Holds `NBANK` register contexts of `NREGS` x `XLEN` bits, so a CGRA tile can switch thread or context by changing `bank_sel` instead of reloading registers.
- Provides `NRD` registered read ports and one write port with same-cycle write-to-read bypass.
- Contains a sequential bank-clear engine that zeroes one register per cycle.
- Sits between decode (read addresses) and writeback (write port) in the PE pipeline.

## Interface
Parameters:
- `XLEN`, 32, data width per register.
- `NREGS`, 32, registers per bank; power of two, ≥2. `AW = $clog2(NREGS)`.
- `NRD`, 2, number of read ports, ≥1.
- `NBANK`, 2, number of banks, ≥2. `BW = $clog2(NBANK)`.
- `ZERO_R0`, 1: when 1, register 0 of every bank reads as 0 and ignores writes.

Ports:
- `clk`  in  1  the block's single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bank_sel`  in  BW  bank used by all read ports.
- `rd_en`  in  NRD  per-port read strobe.
- `rd_addr`  in  NRD*AW  packed read addresses; port i is at `[i*AW +: AW]`.
- `rd_data`  out  NRD*XLEN  packed registered read data.
- `rd_valid`  out  NRD  per-port valid, one cycle after `rd_en`.
- `wr_en`  in  1  write strobe.
- `wr_bank`  in  BW  write bank.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  XLEN  write data.
- `wr_drop`  out  1  one-cycle pulse: the write from the previous cycle was discarded.
- `clr_req`  in  1  request to zero bank `clr_bank`.
- `clr_bank`  in  BW  bank to clear; sampled together with `clr_req`.
- `clr_busy`  out  1  high while a clear is in progress.
- `clr_done`  out  1  one-cycle pulse when a clear completes.

## Operation
- **Storage.** Writes take effect at the rising edge when `wr_en` = 1.
  - A write to address 0 is discarded silently when `ZERO_R0` = 1. This is not a drop: `wr_drop` stays 0.
- **Reads.** At each edge, port i with `rd_en[i]` = 1 registers the data for (`bank_sel`, `rd_addr[i]`) into `rd_data[i]` and sets `rd_valid[i]` = 1.
  - A port with `rd_en[i]` = 0 holds its `rd_data[i]` and sets `rd_valid[i]` = 0.
- **Bypass.** If `wr_en` = 1, `wr_bank` == `bank_sel` and `wr_addr` == `rd_addr[i]` in the same cycle, the registered data is `wr_data` (write-first).
  - Exceptions: the target is r0 with `ZERO_R0` = 1, or the write is dropped. In both cases the stored value is used instead.
- **Clear FSM** (states IDLE, CLEAR):
  - IDLE → CLEAR on `clr_req` = 1. The block latches `clr_bank` and loads idx = 0.
  - In CLEAR, each cycle writes 0 to (latched bank, idx) and increments idx.
  - On idx == NREGS-1 the FSM writes that last register, pulses `clr_done` on the following cycle and returns to IDLE.
  - `clr_req` is ignored while in CLEAR.
- **During CLEAR:**
  - A write targeting the latched bank is discarded, and `wr_drop` pulses on the next cycle.
  - Writes to other banks proceed normally.
  - Reads of the latched bank return 0, whether or not the addressed register has been cleared yet.
- **Simultaneous `clr_req` and `wr_en` to the same bank in IDLE:** the write is performed, then the clear begins on the next cycle and overwrites it with 0.

## Timing
- **Reset** (`rst_n` = 0, asynchronous): all storage = 0, `rd_data` = 0, `rd_valid` = 0, `wr_drop` = 0, `clr_busy` = 0, `clr_done` = 0, FSM = IDLE, idx = 0.
- **Reset mid-clear:** the clear is abandoned and the FSM comes out of reset in IDLE.
- **Read latency:** 1 cycle from `rd_en` to `rd_valid`/`rd_data`. Full throughput: one read per port per cycle.
- **Write latency:** visible to a read issued in the same cycle via bypass, and to any later read from storage.
- **Clear timing:**
  - `clr_busy` rises the cycle after the accepted `clr_req`.
  - It stays high for exactly NREGS cycles.
  - `clr_done` pulses in the first cycle `clr_busy` is low again.
  - Back-to-back: a `clr_req` presented in that `clr_done` cycle is accepted.
- **`wr_drop`:** registered, asserted exactly 1 cycle after the dropped write.

## Structure
- **Package `regfile_pkg`:**
  - Default `XLEN`/`NREGS`/`NBANK`.
  - Typedef `clr_state_t` {IDLE, CLEAR}.
  - Localparam helper for `AW`/`BW` derivation.
- **Sub-module `regfile_bank`:** one bank of NREGS x XLEN flops with a single write port (write mux between normal write and clear write) and combinational read of all entries. Instantiated NBANK times via generate.
- **Top:** bank/port read muxing, bypass compare per port, clear FSM and counter, drop logic.

## Test plan
- **Reset and read:** reset, then read r5 of bank 0 on both ports → `rd_data` = 0, `rd_valid` = 11 one cycle later.
- **Write-then-read across banks:** write bank1/r3 = 0xAAAA0003, then read bank1/r3 and bank0/r3 on successive cycles → 0xAAAA0003, then 0.
- **Bypass and r0:**
  - Same-cycle write bank0/r7 = 0x12345678 with read of r7 on port 0 → `rd_data0` = 0x12345678 next cycle.
  - Write r0 = 0xFFFFFFFF, then read r0 → 0 and `wr_drop` = 0.
- **Clear:**
  - Fill bank1 with 0xAAAA00nn, pulse `clr_req` on bank1 → `clr_busy` high for 32 cycles, then `clr_done` pulses.
  - Every subsequent read of bank1 returns 0; bank0 is unchanged.
- **Contention during clear:**
  - A write to bank1/r9 mid-clear → `wr_drop` = 1 next cycle and r9 reads 0.
  - A write to bank0/r9 succeeds.
  - A second `clr_req` mid-clear is ignored (`clr_busy` length stays 32).
- **Reset mid-clear:** assert `rst_n` = 0 at idx = 10 → FSM in IDLE, all storage 0, `clr_done` never pulses.
